// File: rtl/ocd_io_pkg.sv
// ---------------------------------------------------------------------------
// ocd_io_pkg
// Shared definitions for the OCD I/O-bus master: controller state encoding,
// well-known I/O register addresses and default timing parameters.
// ---------------------------------------------------------------------------
package ocd_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HALT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_RESP      = 2'd3
    } ocd_state_e;

    // Stack pointer and status register locations in I/O space
    localparam logic [5:0] IO_ADR_SPL  = 6'h3D;
    localparam logic [5:0] IO_ADR_SPH  = 6'h3E;
    localparam logic [5:0] IO_ADR_SREG = 6'h3F;

    // cp2 cycles a request may wait for core halt before failing
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int DEFAULT_CNT_W          = 16;

endpackage

// File: rtl/ocd_timeout_cnt.sv
// ---------------------------------------------------------------------------
// ocd_timeout_cnt
// Saturating up-counter used to bound the time a debug request waits for the
// core to halt. Flags terminal count when the count equals TIMEOUT_CYCLES-1.
//
// Ports:
//   cp2    - clock, rising edge
//   ireset - asynchronous active-low reset (count -> 0)
//   i_clr  - synchronous clear (priority over i_en)
//   i_en   - count enable
//   o_tc   - terminal count reached
// ---------------------------------------------------------------------------
module ocd_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic cp2,
    input  logic ireset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            // Hold at all-ones instead of wrapping back to zero
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VALUE);

endmodule

// File: rtl/ocd_io_master.sv
// ---------------------------------------------------------------------------
// ocd_io_master
// Debug-side initiator on the core's internal I/O bus. Accepts one OCD request
// at a time, waits for the core to halt, performs exactly one committed
// (cp2en-qualified) read or write on the I/O bus, then pulses dbg_ack.
//
// Ports:
//   cp2, ireset            - clock (rising edge) / async active-low reset
//   cp2en                  - core clock enable; bus access commits only when 1
//   core_halted            - core stopped, bus owned by this block
//   dbg_req/we/adr/wdata   - request strobe (sampled in IDLE) and its payload
//   dbg_abort              - cancel the outstanding request
//   dbg_busy               - request in progress
//   dbg_ack, dbg_err       - one-cycle completion pulse and its error status
//   dbg_rdata              - last successful read result
//   adr/iowe/iore/dbusout  - I/O bus address, strobes and write data
//   dbusin                 - I/O bus read data (combinational)
// ---------------------------------------------------------------------------
module ocd_io_master
    import ocd_io_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic       cp2en,
    input  logic       core_halted,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [5:0] dbg_adr,
    input  logic [7:0] dbg_wdata,
    input  logic       dbg_abort,
    output logic       dbg_busy,
    output logic       dbg_ack,
    output logic       dbg_err,
    output logic [7:0] dbg_rdata,
    output logic [5:0] adr,
    output logic       iowe,
    output logic       iore,
    output logic [7:0] dbusout,
    input  logic [7:0] dbusin
);

    ocd_state_e r_state, w_next;

    logic       r_we;
    logic [5:0] r_lat_adr;
    logic [7:0] r_lat_wdata;
    logic [5:0] r_adr;
    logic [7:0] r_dbusout;
    logic [7:0] r_rdata;
    logic       r_err;

    logic       w_err_next;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_tc;
    logic       w_iowe;
    logic       w_iore;
    logic       w_commit;

    ocd_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_cnt (
        .cp2    (cp2),
        .ireset (ireset),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_tc   (w_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next     = r_state;
        w_err_next = r_err;
        w_cnt_clr  = 1'b0;
        w_cnt_en   = 1'b0;
        w_iowe     = 1'b0;
        w_iore     = 1'b0;
        w_commit   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (dbg_req) begin
                    w_next    = ST_WAIT_HALT;
                    w_cnt_clr = 1'b1;
                end
            end

            ST_WAIT_HALT: begin
                if (dbg_abort) begin
                    w_next     = ST_RESP;
                    w_err_next = 1'b1;
                end else if (core_halted) begin
                    w_next = ST_ACCESS;
                end else if (w_tc) begin
                    w_next     = ST_RESP;
                    w_err_next = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end

            ST_ACCESS: begin
                // Abort outranks a coinciding commit: no strobe, no write
                if (dbg_abort) begin
                    w_next     = ST_RESP;
                    w_err_next = 1'b1;
                end else if (!core_halted) begin
                    // Bus lost before commit; keep the timeout budget running
                    w_next = ST_WAIT_HALT;
                end else begin
                    // Strobes stay up across cp2en=0 cycles; the register
                    // file only acts on the one cycle with cp2en=1
                    w_iowe = r_we;
                    w_iore = !r_we;
                    if (cp2en) begin
                        w_commit   = 1'b1;
                        w_next     = ST_RESP;
                        w_err_next = 1'b0;
                    end
                end
            end

            ST_RESP: begin
                w_next = ST_IDLE;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_lat_adr   <= '0;
            r_lat_wdata <= '0;
            r_adr       <= '0;
            r_dbusout   <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;

            if ((r_state == ST_IDLE) && dbg_req) begin
                r_we        <= dbg_we;
                r_lat_adr   <= dbg_adr;
                r_lat_wdata <= dbg_wdata;
            end

            // Bus address/data only change when entering ACCESS, so they
            // hold their last value everywhere else
            if (w_next == ST_ACCESS) begin
                r_adr     <= r_lat_adr;
                r_dbusout <= r_lat_wdata;
            end

            if (w_commit && !r_we) begin
                r_rdata <= dbusin;
            end
        end
    end

    assign dbg_busy  = (r_state != ST_IDLE);
    assign dbg_ack   = (r_state == ST_RESP);
    assign dbg_err   = (r_state == ST_RESP) && r_err;
    assign dbg_rdata = r_rdata;
    assign adr       = r_adr;
    assign dbusout   = r_dbusout;
    assign iowe      = w_iowe;
    assign iore      = w_iore;

endmodule

// File: tb/tb_ocd_io_master.sv
// ---------------------------------------------------------------------------
// tb_ocd_io_master
// Self-checking bench for ocd_io_master. A behavioural 64-byte I/O register
// file is attached to the bus. Directed table rows cover the named scenarios;
// random transactions are checked against a transaction-level model (a
// shadow array plus closed-form latency rules).
// ---------------------------------------------------------------------------
module tb_ocd_io_master;
    import ocd_io_pkg::*;

    localparam int T_CYC = 4;

    logic       cp2         = 1'b0;
    logic       ireset      = 1'b0;
    logic       cp2en       = 1'b0;
    logic       core_halted = 1'b0;
    logic       dbg_req     = 1'b0;
    logic       dbg_we      = 1'b0;
    logic [5:0] dbg_adr     = '0;
    logic [7:0] dbg_wdata   = '0;
    logic       dbg_abort   = 1'b0;
    logic       dbg_busy, dbg_ack, dbg_err;
    logic [7:0] dbg_rdata;
    logic [5:0] adr;
    logic       iowe, iore;
    logic [7:0] dbusout;
    logic [7:0] dbusin;

    logic       tb_init = 1'b1;
    logic [7:0] mem    [64];
    logic [7:0] shadow [64];
    logic [7:0] exp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    ocd_io_master #(
        .TIMEOUT_CYCLES (T_CYC),
        .CNT_W          (16)
    ) dut (
        .cp2         (cp2),
        .ireset      (ireset),
        .cp2en       (cp2en),
        .core_halted (core_halted),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_adr     (dbg_adr),
        .dbg_wdata   (dbg_wdata),
        .dbg_abort   (dbg_abort),
        .dbg_busy    (dbg_busy),
        .dbg_ack     (dbg_ack),
        .dbg_err     (dbg_err),
        .dbg_rdata   (dbg_rdata),
        .adr         (adr),
        .iowe        (iowe),
        .iore        (iore),
        .dbusout     (dbusout),
        .dbusin      (dbusin)
    );

    always #5 cp2 = ~cp2;

    // Behavioural I/O register file: all zero except SPH, which resets to 04
    assign dbusin = mem[adr];
    always @(posedge cp2) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[IO_ADR_SPH] <= 8'h04;
        end else if (iowe && cp2en) begin
            mem[adr] <= dbusout;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request and observes it until ack (bounded). Bit s of the
    // masks gives cp2en / core_halted in cycle s (cycle 0 = request cycle).
    task automatic run_txn(input string name, input logic we, input logic [5:0] a,
                           input logic [7:0] d, input logic [31:0] en_mask,
                           input logic [31:0] halt_mask, input int abort_at,
                           input logic hold_req, input int exp_lat, input logic exp_err,
                           input int exp_strobes, input int exp_commits);
        int   lat     = 0;
        logic err     = 1'b0;
        int   strobes = 0;
        int   commits = 0;
        int   bus_bad = 0;
        @(posedge cp2); #1;
        dbg_req     = 1'b1;
        dbg_we      = we;
        dbg_adr     = a;
        dbg_wdata   = d;
        cp2en       = en_mask[0];
        core_halted = halt_mask[0];
        dbg_abort   = 1'b0;
        for (int s = 1; s <= 40 && lat == 0; s++) begin
            @(posedge cp2); #1;
            // Change the request inputs while busy: must be ignored
            dbg_req     = hold_req;
            dbg_we      = ~we;
            dbg_adr     = a ^ 6'h15;
            dbg_wdata   = ~d;
            cp2en       = (s < 32) ? en_mask[s] : 1'b1;
            core_halted = (s < 32) ? halt_mask[s] : halt_mask[31];
            dbg_abort   = (s == abort_at);
            @(negedge cp2);
            if (iowe || iore) begin
                strobes++;
                if (cp2en) commits++;
                if (adr !== a) bus_bad++;
                if (iowe && (!we || dbusout !== d)) bus_bad++;
                if (iore && we) bus_bad++;
            end
            if (dbg_ack) begin
                lat = s;
                err = dbg_err;
            end
        end
        @(posedge cp2); #1;
        dbg_req   = 1'b0;
        dbg_abort = 1'b0;
        cp2en     = 1'b1;
        @(negedge cp2);
        check({name, ".lat"},     lat,     exp_lat);
        check({name, ".err"},     err,     exp_err);
        check({name, ".strobes"}, strobes, exp_strobes);
        check({name, ".commits"}, commits, exp_commits);
        check({name, ".bus"},     bus_bad, 0);
        check({name, ".idle"},    {dbg_busy, dbg_ack}, 0);
    endtask

    // Transaction-level expectations from the timing rules: ACCESS is reached
    // in cycle 2 when halted, commit happens in the first cp2en cycle from
    // there, ack appears the cycle after the deciding cycle.
    function automatic void model(input logic halted, input int p, input int a,
                                  output int lat, output logic err,
                                  output int strobes, output int commits);
        int commit_s;
        strobes = 0;
        commits = 0;
        if (!halted) begin
            err = 1'b1;
            lat = (a >= 1 && a <= T_CYC) ? a + 1 : T_CYC + 1;
        end else begin
            commit_s = 2;
            while (commit_s % p != 0) commit_s++;
            if (a >= 1 && a <= commit_s) begin
                err     = 1'b1;
                lat     = a + 1;
                strobes = (a > 2) ? a - 2 : 0;
            end else begin
                err     = 1'b0;
                lat     = commit_s + 1;
                strobes = commit_s - 1;
                commits = 1;
            end
        end
    endfunction

    function automatic void shadow_update(input logic we, input logic [5:0] a,
                                          input logic [7:0] d, input logic err);
        if (!err) begin
            if (we) shadow[a] = d;
            else    exp_rdata = shadow[a];
        end
    endfunction

    typedef struct {
        logic        we;
        logic [5:0]  a;
        logic [7:0]  d;
        logic [31:0] en;
        logic [31:0] halt;
        int          abort_at;
        logic        hold;
        int          lat;
        logic        err;
        int          strobes;
        int          commits;
        logic [7:0]  rdata;
        logic [7:0]  memv;
    } vec_t;

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] EN3 = 32'h4924_9249;  // cp2en every third cycle

    task automatic run_table();
        vec_t vecs[9];
        vecs[0] = '{1'b1, IO_ADR_SPL,  8'hA5, ALL,           ALL,           0, 1'b0, 3,         1'b0, 1, 1, 8'h00, 8'hA5};
        vecs[1] = '{1'b0, IO_ADR_SPH,  8'h00, ALL,           ALL,           0, 1'b1, 3,         1'b0, 1, 1, 8'h04, 8'h04};
        vecs[2] = '{1'b1, IO_ADR_SREG, 8'h81, EN3,           ALL,           0, 1'b0, 4,         1'b0, 2, 1, 8'h04, 8'h81};
        vecs[3] = '{1'b0, IO_ADR_SPL,  8'h00, ALL,           32'h0,         0, 1'b0, T_CYC + 1, 1'b1, 0, 0, 8'h04, 8'hA5};
        vecs[4] = '{1'b1, IO_ADR_SPL,  8'h5A, ALL,           ALL,           2, 1'b0, 3,         1'b1, 0, 0, 8'h04, 8'hA5};
        vecs[5] = '{1'b1, IO_ADR_SPH,  8'h77, 32'hFFFF_FFE0, 32'hFFFF_FFF7, 0, 1'b0, 6,         1'b0, 2, 1, 8'h04, 8'h77};
        vecs[6] = '{1'b0, IO_ADR_SPH,  8'h00, ALL,           32'h0,         2, 1'b0, 3,         1'b1, 0, 0, 8'h04, 8'h77};
        vecs[7] = '{1'b1, IO_ADR_SREG, 8'h00, EN3,           ALL,           3, 1'b0, 4,         1'b1, 1, 0, 8'h04, 8'h81};
        vecs[8] = '{1'b0, IO_ADR_SREG, 8'h00, ALL,           ALL,           0, 1'b0, 3,         1'b0, 1, 1, 8'h81, 8'h81};
        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_txn(nm, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].en, vecs[i].halt,
                    vecs[i].abort_at, vecs[i].hold, vecs[i].lat, vecs[i].err,
                    vecs[i].strobes, vecs[i].commits);
            check({nm, ".rdata"}, dbg_rdata, vecs[i].rdata);
            check({nm, ".mem"},   mem[vecs[i].a], vecs[i].memv);
            shadow_update(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].err);
        end
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            logic        we;
            logic [5:0]  a;
            logic [7:0]  d;
            logic        halted;
            int          p, ab, lat, strobes, commits;
            logic        err;
            logic [31:0] en_mask;
            string       nm;
            we      = 1'($urandom_range(0, 1));
            a       = 6'($urandom_range(0, 63));
            d       = 8'($urandom_range(0, 255));
            halted  = ($urandom_range(0, 4) != 0);
            p       = $urandom_range(1, 3);
            ab      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            for (int s = 0; s < 32; s++) en_mask[s] = (s % p == 0);
            model(halted, p, ab, lat, err, strobes, commits);
            nm = $sformatf("rnd%0d", k);
            run_txn(nm, we, a, d, en_mask, halted ? ALL : 32'h0, ab,
                    1'($urandom_range(0, 1)), lat, err, strobes, commits);
            shadow_update(we, a, d, err);
            check({nm, ".rdata"}, dbg_rdata, exp_rdata);
            check({nm, ".mem"},   mem[a],    shadow[a]);
        end
    endtask

    task automatic run_reset_mid_access();
        int stray = 0;
        @(posedge cp2); #1;
        dbg_req     = 1'b1;
        dbg_we      = 1'b1;
        dbg_adr     = 6'h3C;
        dbg_wdata   = 8'h33;
        cp2en       = 1'b0;
        core_halted = 1'b1;
        @(posedge cp2); #1;
        dbg_req = 1'b0;
        @(posedge cp2); #1;
        @(negedge cp2);
        check("rst_mid.iowe_before", iowe, 1);
        #2 ireset = 1'b0;
        #1;
        check("rst_mid.busy",    dbg_busy,  0);
        check("rst_mid.ack",     dbg_ack,   0);
        check("rst_mid.iowe",    iowe,      0);
        check("rst_mid.adr",     adr,       0);
        check("rst_mid.dbusout", dbusout,   0);
        check("rst_mid.rdata",   dbg_rdata, 0);
        @(posedge cp2); #1;
        ireset = 1'b1;
        cp2en  = 1'b1;
        repeat (4) begin
            @(negedge cp2);
            if (dbg_ack || dbg_busy || iowe) stray++;
        end
        check("rst_mid.no_ack", stray, 0);
        check("rst_mid.mem", mem[6'h3C], shadow[6'h3C]);
        exp_rdata = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        shadow[IO_ADR_SPH] = 8'h04;
        exp_rdata = 8'h00;

        repeat (3) @(posedge cp2);
        #1;
        check("rst.busy",    dbg_busy,  0);
        check("rst.ack",     dbg_ack,   0);
        check("rst.err",     dbg_err,   0);
        check("rst.iowe",    iowe,      0);
        check("rst.iore",    iore,      0);
        check("rst.adr",     adr,       0);
        check("rst.dbusout", dbusout,   0);
        check("rst.rdata",   dbg_rdata, 0);
        tb_init = 1'b0;
        ireset  = 1'b1;

        run_table();
        run_random(40);
        run_reset_mid_access();

        run_txn("post_rst", 1'b0, IO_ADR_SPH, 8'h00, ALL, ALL, 0, 1'b0, 3, 1'b0, 1, 1);
        shadow_update(1'b0, IO_ADR_SPH, 8'h00, 1'b0);
        check("post_rst.rdata", dbg_rdata, exp_rdata);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ocd_io_master.md
Name: ocd_io_master

Overview:
- Debug-side initiator on the core's internal I/O bus. It lets the JTAG OCD read and write I/O registers (SPL/SPH/SREG and any other 6-bit I/O address) while the core is halted.
- It accepts one debug request at a time over a req/ack handshake. It waits for core halt, drives adr/iowe/iore/dbusout for exactly one cp2en-qualified cycle, then returns the result.
- It sits between the OCD command decoder and the I/O bus mux that feeds io_reg_file and the peripheral read mux.

Parameters:
- TIMEOUT_CYCLES, 255, cp2 cycles allowed in WAIT_HALT before the request fails with an error; valid range 1..65535.
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- cp2  input  1  core clock; all state updates on rising edge
- ireset  input  1  asynchronous active-low reset
- cp2en  input  1  core clock enable; a bus access is committed only in a cycle with cp2en=1
- core_halted  input  1  core stopped by OCD; the bus is free for this block
- dbg_req  input  1  request strobe, sampled only in IDLE
- dbg_we  input  1  1=write, 0=read
- dbg_adr  input  6  I/O address
- dbg_wdata  input  8  write data
- dbg_abort  input  1  cancel the outstanding request
- dbg_busy  output  1  request in progress (state != IDLE)
- dbg_ack  output  1  one-cycle completion pulse
- dbg_err  output  1  completion status, valid with dbg_ack (timeout or abort)
- dbg_rdata  output  8  read result, held until the next accepted request
- adr  output  6  I/O address to the bus
- iowe  output  1  I/O write strobe
- iore  output  1  I/O read strobe
- dbusout  output  8  write data to the bus
- dbusin  input  8  I/O read data; combinational, valid in the same cycle as iore

Behaviour:
- Reset: state=IDLE. dbg_busy, dbg_ack, dbg_err, iowe and iore are 0. adr=0, dbusout=0, dbg_rdata=0, counter=0. Reset mid-operation aborts silently with no ack.
- States: IDLE, WAIT_HALT, ACCESS, RESP.
- IDLE: when dbg_req=1, latch we/adr/wdata, clear the counter, go to WAIT_HALT. dbg_req is ignored in every other state and is not queued.
- WAIT_HALT: when core_halted=1, go to ACCESS next cycle. Otherwise the counter increments each cycle. When counter==TIMEOUT_CYCLES-1 and core is still not halted, go to RESP with err=1.
- ACCESS:
  - adr=latched adr, dbusout=latched wdata. iowe=we or iore=!we, gated by core_halted.
  - In a cycle with cp2en=1 and core_halted=1: a read captures dbusin into dbg_rdata; then go to RESP with err=0.
  - If core_halted falls before a cp2en cycle, drop the strobes and return to WAIT_HALT without clearing the counter.
  - The strobes are held across cp2en=0 cycles; the register file ignores them there, so exactly one access commits.
- RESP: dbg_ack=1 for one cycle with dbg_err valid, then go to IDLE. Latency with core already halted and cp2en=1 throughout: req sampled at edge 0, strobe during cycle 1-2, ack in cycle 3 (3 cycles).
- dbg_abort=1 in WAIT_HALT or ACCESS goes to RESP with err=1. If abort and a committing cp2en coincide in ACCESS, abort wins: strobes are suppressed that cycle and no write occurs. Abort in IDLE or RESP has no effect.
- Outside ACCESS, adr and dbusout hold their last value and iowe/iore are 0.
- At most one strobe per request. iowe and iore are never 1 simultaneously.
- Error completions leave dbg_rdata unchanged.
- The counter saturates; it never wraps.

Decomposition:
- Package ocd_io_pkg holds:
  - the state enum;
  - I/O address constants: SPL 6'h3D, SPH 6'h3E, SREG 6'h3F;
  - the default TIMEOUT_CYCLES.
- One sub-module, ocd_timeout_cnt: clear, enable, saturating CNT_W counter, terminal-count flag at TIMEOUT_CYCLES-1.

Test Plan:
- Halted, cp2en=1; write adr=6'h3D data=8'hA5 -> iowe high exactly 1 cycle with adr=3D, dbusout=A5; spl_out of the attached io_reg_file becomes A5; dbg_ack with err=0.
- Halted, after reset; read adr=6'h3E -> iore 1 cycle, dbg_rdata=8'h04 (SPH reset value), ack err=0; a second request while busy is ignored.
- cp2en toggling 1-in-3, write SREG=8'h81 -> strobe held until the cp2en cycle; sreg_out=81; ack follows that cycle.
- core_halted=0, TIMEOUT_CYCLES=4 -> no strobes; ack err=1 four cycles after WAIT_HALT entry; dbg_rdata unchanged.
- Abort in the same cycle as the committing cp2en during a write to 6'h3D -> iowe=0, SPL unchanged, ack err=1.
- ireset asserted during ACCESS -> all outputs 0 immediately, no ack; the next request completes normally.
